line_clear_sequencer: RTL and testbench

- Sequences line clearing on the fixed playfield after each piece lock; sits between the lock logic and the fixed-board storage.
- On a lock pulse it scans the board bottom-to-top one row per cycle, compacts non-full rows downward, zero-fills the vacated top rows, updates line counters and checks for game over.
- Drives `clearing_line` to hold gravity and new-piece insertion while it owns the board.

---
 rtl/line_clear_sequencer.sv | 142 ++++++++++++++
 tb/tb_line_clear_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/line_clear_sequencer.sv
// Line-clear sequencer: after each piece lock it scans the fixed board bottom-up,
// drops non-full rows over removed ones, zero-fills the top and tracks line counts.
module line_clear_sequencer #(
  parameter int ROWS   = 20,
  parameter int COLS   = 10,
  parameter int ROW_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              game_clk,
  input  logic              reset,
  input  logic              lock,
  output logic [ROW_AW-1:0] row_rd_addr,
  input  logic [COLS-1:0]   row_rd_data,
  output logic              row_wr_en,
  output logic [ROW_AW-1:0] row_wr_addr,
  output logic [COLS-1:0]   row_wr_data,
  output logic              clearing_line,
  output logic              clear_done,
  output logic [ROW_AW-1:0] lines_cleared,
  output logic [CNT_W-1:0]  total_lines,
  output logic              game_over,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_FILL  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int SW = ((CNT_W > ROW_AW) ? CNT_W : ROW_AW) + 1;

  state_t                    state_q, state_d;
  logic [ROW_AW-1:0]         src_q, src_d;
  logic signed [ROW_AW:0]    dst_q, dst_d;
  logic [ROW_AW-1:0]         cnt_q, cnt_d;
  logic [ROW_AW-1:0]         lines_q, lines_d;
  logic [CNT_W-1:0]          total_q, total_d;
  logic                      over_q, over_d;
  logic [SW-1:0]             sum_w;

  // Handshake: lock is a fire-and-forget pulse accepted only in IDLE with game_over
  // clear; clearing_line marks board ownership and clear_done pulses once at the end.
  always_ff @(posedge game_clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      lines_q <= '0;
      total_q <= '0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
      total_q <= total_d;
      over_q  <= over_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    cnt_d       = cnt_q;
    lines_d     = lines_q;
    total_d     = total_q;
    over_d      = over_q;
    row_rd_addr = '0;
    row_wr_en   = 1'b0;
    row_wr_addr = '0;
    row_wr_data = '0;
    sum_w       = SW'(total_q) + SW'(cnt_q);

    unique case (state_q)
      S_IDLE: begin
        if (lock && !over_q) begin
          src_d   = ROW_AW'(ROWS - 1);
          dst_d   = (ROW_AW + 1)'(ROWS - 1);
          cnt_d   = '0;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        row_rd_addr = src_q;
        if (&row_rd_data) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          // dst never drops below src here, so the write lands on a row already read.
          if ({1'b0, src_q} != dst_q) begin
            row_wr_en   = 1'b1;
            row_wr_addr = dst_q[ROW_AW-1:0];
            row_wr_data = row_rd_data;
          end
          dst_d = dst_q - 1'b1;
        end
        if (src_q == '0) begin
          state_d = (cnt_d != '0) ? S_FILL : S_CHECK;
        end else begin
          src_d = src_q - 1'b1;
        end
      end

      S_FILL: begin
        row_wr_en   = 1'b1;
        row_wr_addr = dst_q[ROW_AW-1:0];
        row_wr_data = '0;
        dst_d       = dst_q - 1'b1;
        if (dst_q == '0) state_d = S_CHECK;
      end

      S_CHECK: begin
        row_rd_addr = '0;
        if (|row_rd_data) over_d = 1'b1;
        state_d = S_DONE;
      end

      S_DONE: begin
        lines_d = cnt_q;
        if (sum_w > SW'({CNT_W{1'b1}})) total_d = '1;
        else                            total_d = sum_w[CNT_W-1:0];
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign clearing_line = (state_q != S_IDLE);
  assign clear_done    = (state_q == S_DONE);
  assign lines_cleared = lines_q;
  assign total_lines   = total_q;
  assign game_over     = over_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_line_clear_sequencer.sv
// Directed bench for line_clear_sequencer: two instances (default counter width and a
// narrow one for saturation), each with a behavioural board memory.
module tb_line_clear_sequencer;
  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int AW   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, lock, sel, load_a, load_b;
  logic lock_a, lock_b;
  assign lock_a = lock & ~sel;
  assign lock_b = lock & sel;

  logic [COLS-1:0] img     [ROWS];
  logic [COLS-1:0] exp_img [ROWS];
  logic [COLS-1:0] board_a [ROWS];
  logic [COLS-1:0] board_b [ROWS];

  logic [AW-1:0]   rd_addr_a, wr_addr_a, lines_a, rd_addr_b, wr_addr_b, lines_b;
  logic [COLS-1:0] rd_data_a, wr_data_a, rd_data_b, wr_data_b;
  logic            wr_en_a, cl_a, done_a, go_a, wr_en_b, cl_b, done_b, go_b;
  logic [15:0]     total_a;
  logic [4:0]      total_b;
  logic [2:0]      st_a, st_b;

  line_clear_sequencer #(.ROWS(ROWS), .COLS(COLS), .ROW_AW(AW), .CNT_W(16)) dut_a (
    .game_clk(clk), .reset(rst), .lock(lock_a),
    .row_rd_addr(rd_addr_a), .row_rd_data(rd_data_a),
    .row_wr_en(wr_en_a), .row_wr_addr(wr_addr_a), .row_wr_data(wr_data_a),
    .clearing_line(cl_a), .clear_done(done_a), .lines_cleared(lines_a),
    .total_lines(total_a), .game_over(go_a), .dbg_state(st_a)
  );

  line_clear_sequencer #(.ROWS(ROWS), .COLS(COLS), .ROW_AW(AW), .CNT_W(5)) dut_b (
    .game_clk(clk), .reset(rst), .lock(lock_b),
    .row_rd_addr(rd_addr_b), .row_rd_data(rd_data_b),
    .row_wr_en(wr_en_b), .row_wr_addr(wr_addr_b), .row_wr_data(wr_data_b),
    .clearing_line(cl_b), .clear_done(done_b), .lines_cleared(lines_b),
    .total_lines(total_b), .game_over(go_b), .dbg_state(st_b)
  );

  assign rd_data_a = (rd_addr_a < AW'(ROWS)) ? board_a[rd_addr_a] : '0;
  assign rd_data_b = (rd_addr_b < AW'(ROWS)) ? board_b[rd_addr_b] : '0;

  always @(posedge clk) begin
    if (load_a) board_a <= img;
    else if (wr_en_a) board_a[wr_addr_a] <= wr_data_a;
    if (load_b) board_b <= img;
    else if (wr_en_b) board_b[wr_addr_b] <= wr_data_b;
  end

  logic m_cl, m_done, m_wr;
  assign m_cl   = sel ? cl_b   : cl_a;
  assign m_done = sel ? done_b : done_a;
  assign m_wr   = sel ? wr_en_b : wr_en_a;

  int compared   = 0;
  int mismatched = 0;
  int done_cyc, cl_cyc, wr_cyc, dones;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_imgs();
    for (int r = 0; r < ROWS; r++) begin
      img[r]     = '0;
      exp_img[r] = '0;
    end
  endtask

  task automatic do_load(input logic which);
    if (which) load_b = 1'b1;
    else       load_a = 1'b1;
    tick();
    load_a = 1'b0;
    load_b = 1'b0;
  endtask

  // Pulses lock, then observes a fixed 60-cycle window counting busy/write/done cycles.
  task automatic run_seq(input int relock_at);
    lock = 1'b1;
    tick();
    done_cyc = -1;
    cl_cyc   = 0;
    wr_cyc   = 0;
    dones    = 0;
    for (int c = 1; c <= 60; c++) begin
      lock = (c == relock_at);
      if (m_cl) cl_cyc++;
      if (m_wr) wr_cyc++;
      if (m_done) begin
        dones++;
        if (done_cyc < 0) done_cyc = c;
      end
      tick();
    end
    lock = 1'b0;
  endtask

  task automatic check_board_a(input string tag);
    for (int r = 0; r < ROWS; r++)
      chk($sformatf("%s_row%0d", tag, r), 32'(board_a[r]), 32'(exp_img[r]));
  endtask

  initial begin
    rst = 1'b1; lock = 1'b0; sel = 1'b0; load_a = 1'b0; load_b = 1'b0;
    clear_imgs();
    tick(); tick();
    chk("rst_clearing", 32'(cl_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_wr_en", 32'(wr_en_a), 0);
    chk("rst_rd_addr", 32'(rd_addr_a), 0);
    chk("rst_total", 32'(total_a), 0);
    chk("rst_game_over", 32'(go_a), 0);
    chk("rst_state", 32'(st_a), 0);
    rst = 1'b0;
    tick();

    // Empty board: no writes, 22 busy cycles.
    clear_imgs(); do_load(1'b0); run_seq(0);
    chk("t1_done_cyc", 32'(done_cyc), 22);
    chk("t1_busy", 32'(cl_cyc), 22);
    chk("t1_writes", 32'(wr_cyc), 0);
    chk("t1_lines", 32'(lines_a), 0);
    chk("t1_total", 32'(total_a), 0);
    chk("t1_idle_rd_addr", 32'(rd_addr_a), 0);

    // Bottom row full, row 18 drops into it.
    clear_imgs(); img[19] = 10'h3FF; img[18] = 10'h001; exp_img[19] = 10'h001;
    do_load(1'b0); run_seq(0);
    chk("t2_done_cyc", 32'(done_cyc), 23);
    chk("t2_writes", 32'(wr_cyc), 20);
    chk("t2_lines", 32'(lines_a), 1);
    chk("t2_total", 32'(total_a), 1);
    check_board_a("t2");

    // Four full rows with a partial row above.
    clear_imgs();
    for (int r = 16; r < ROWS; r++) img[r] = 10'h3FF;
    img[15] = 10'h3F0; exp_img[19] = 10'h3F0;
    do_load(1'b0); run_seq(0);
    chk("t3_done_cyc", 32'(done_cyc), 26);
    chk("t3_writes", 32'(wr_cyc), 20);
    chk("t3_lines", 32'(lines_a), 4);
    chk("t3_total", 32'(total_a), 5);
    check_board_a("t3");

    // Second lock mid-scan is dropped.
    do_load(1'b0); run_seq(5);
    chk("t5_done_cyc", 32'(done_cyc), 26);
    chk("t5_done_count", 32'(dones), 1);
    chk("t5_lines", 32'(lines_a), 4);
    chk("t5_total", 32'(total_a), 9);

    // Reset while filling, then a fresh sequence.
    do_load(1'b0);
    lock = 1'b1; tick(); lock = 1'b0;
    repeat (21) tick();
    chk("t6_in_fill", 32'(st_a), 2);
    chk("t6_fill_wr", 32'(wr_en_a), 1);
    rst = 1'b1;
    #1;
    chk("t6_async_clearing", 32'(cl_a), 0);
    chk("t6_async_wr_en", 32'(wr_en_a), 0);
    chk("t6_async_wr_addr", 32'(wr_addr_a), 0);
    chk("t6_async_total", 32'(total_a), 0);
    chk("t6_async_lines", 32'(lines_a), 0);
    chk("t6_async_state", 32'(st_a), 0);
    tick(); rst = 1'b0; tick();
    clear_imgs(); img[19] = 10'h3FF; img[18] = 10'h3FF; img[17] = 10'h155; exp_img[19] = 10'h155;
    do_load(1'b0); run_seq(0);
    chk("t6_done_cyc", 32'(done_cyc), 24);
    chk("t6_writes", 32'(wr_cyc), 20);
    chk("t6_lines", 32'(lines_a), 2);
    chk("t6_total", 32'(total_a), 2);
    check_board_a("t6");

    // Occupied top row: game over, later locks ignored.
    clear_imgs(); img[0] = 10'h010;
    do_load(1'b0); run_seq(0);
    chk("t4_done_cyc", 32'(done_cyc), 22);
    chk("t4_writes", 32'(wr_cyc), 0);
    chk("t4_game_over", 32'(go_a), 1);
    chk("t4_total", 32'(total_a), 2);
    run_seq(0);
    chk("t4_relock_done", 32'(done_cyc), 32'hFFFF_FFFF);
    chk("t4_relock_busy", 32'(cl_cyc), 0);
    chk("t4_relock_sticky", 32'(go_a), 1);

    // Narrow counter instance: full board twice, total saturates at 31.
    sel = 1'b1;
    clear_imgs();
    for (int r = 0; r < ROWS; r++) img[r] = 10'h3FF;
    do_load(1'b1); run_seq(0);
    chk("b1_done_cyc", 32'(done_cyc), 42);
    chk("b1_busy", 32'(cl_cyc), 42);
    chk("b1_writes", 32'(wr_cyc), 20);
    chk("b1_lines", 32'(lines_b), 20);
    chk("b1_total", 32'(total_b), 20);
    chk("b1_game_over", 32'(go_b), 0);
    chk("b1_row0", 32'(board_b[0]), 0);
    chk("b1_row19", 32'(board_b[19]), 0);
    do_load(1'b1); run_seq(0);
    chk("b2_done_cyc", 32'(done_cyc), 42);
    chk("b2_total_sat", 32'(total_b), 31);
    chk("b2_lines", 32'(lines_b), 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
